// File: rtl/edge_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : edge_arb_pkg
//  Description : Shared constants for the edge event arbiter: edge-select
//                codes, output FSM state encoding and a clog2 helper used to
//                size the channel index.
//  Revision    : 1.0  initial release
// ============================================================================
package edge_arb_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

  // Smallest w with 2**w >= value; used at elaboration time only.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int w = 30; w >= 0; w--) begin
      if ((1 << w) >= value) result = w;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_det_sync.sv
`default_nettype none
// ============================================================================
//  Module      : edge_det_sync
//  Description : Single-channel edge detector. Optional 2-flop synchronizer,
//                a delayed copy of the level (in_d) and an EDGE_SEL qualifier.
//                Produces a one-cycle edge pulse, suppressed while rst=1.
//  Revision    : 1.0  initial release
//  Macro       : EDGE_ARB_SYNC_EN - adds a 2-flop synchronizer ahead of in_d
//  Ports       : clk     - clock
//                rst     - synchronous active-high reset (gates the pulse)
//                in_i    - raw level input
//                edge_o  - one-cycle edge pulse
// ============================================================================
module edge_det_sync
  import edge_arb_pkg::*;
#(
  parameter int EDGE_SEL = EDGE_RISE
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic edge_o
);

  logic lvl_w;
  logic in_d_q;
  logic edge_w;

`ifdef EDGE_ARB_SYNC_EN
  logic [1:0] sync_q;

  // Shifts during reset as well so the history is valid once rst drops.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[0], in_i};
  end
  assign lvl_w = sync_q[1];
`else
  assign lvl_w = in_i;
`endif

  // Deliberately not reset: a level held through reset must already be in
  // the history when rst drops, otherwise it would look like an edge.
  always_ff @(posedge clk) begin
    in_d_q <= lvl_w;
  end

  if (EDGE_SEL == EDGE_FALL) begin : g_fall
    assign edge_w = ~lvl_w & in_d_q;
  end else if (EDGE_SEL == EDGE_BOTH) begin : g_both
    assign edge_w = lvl_w ^ in_d_q;
  end else begin : g_rise
    assign edge_w = lvl_w & ~in_d_q;
  end

  assign edge_o = edge_w & ~rst;

endmodule
`default_nettype wire

// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : edge_event_arbiter
//  Description : Detects edges on N_CH inputs, keeps a saturating pending
//                count per channel and serves channels round-robin onto a
//                single valid/ready event port (up to one event per clock).
//  Revision    : 1.0  initial release
//  Macro       : EDGE_ARB_SYNC_EN - per-channel 2-flop input synchronizer
//  Ports       : clk        - clock, all logic on posedge
//                rst        - synchronous active-high reset
//                in_i       - raw level inputs [N_CH]
//                ev_valid_o - event available
//                ev_ready_i - consumer accepts event
//                ev_ch_o    - channel index of offered event
//                ovf_o      - sticky per-channel overflow [N_CH]
//                ovf_clr_i  - per-bit clear pulse for ovf_o [N_CH]
// ============================================================================
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 3,
  parameter int EDGE_SEL = EDGE_RISE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          in_i,
  output logic                     ev_valid_o,
  input  logic                     ev_ready_i,
  output logic [clog2(N_CH)-1:0]   ev_ch_o,
  output logic [N_CH-1:0]          ovf_o,
  input  logic [N_CH-1:0]          ovf_clr_i
);

  localparam int              CH_W      = clog2(N_CH);
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CH_W-1:0]  C_PTR_RST = CH_W'(N_CH - 1);

  logic [N_CH-1:0]  edge_w;
  logic [N_CH-1:0]  pend_nz_w;
  logic [N_CH-1:0]  dec_w;
  logic [N_CH-1:0]  ovf_set_w;
  logic [CNT_W-1:0] pend_q [N_CH];
  logic [CNT_W-1:0] pend_d [N_CH];
  logic [N_CH-1:0]  ovf_q;
  logic [N_CH-1:0]  ovf_d;
  logic [CH_W-1:0]  grant_w;
  logic             found_w;
  logic             load_w;

  arb_state_e       state_q;
  logic             ev_valid_q;
  logic [CH_W-1:0]  ev_ch_q;
  logic [CH_W-1:0]  ptr_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_det_sync #(
      .EDGE_SEL (EDGE_SEL)
    ) u_edge (
      .clk    (clk),
      .rst    (rst),
      .in_i   (in_i[i]),
      .edge_o (edge_w[i])
    );
    assign pend_nz_w[i] = (pend_q[i] != '0);
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    int idx;
    found_w = 1'b0;
    grant_w = '0;
    for (int off = 1; off <= N_CH; off++) begin
      idx = (int'(ptr_q) + off) % N_CH;
      if (!found_w && pend_nz_w[idx]) begin
        found_w = 1'b1;
        grant_w = CH_W'(idx);
      end
    end
  end

  // The output register can take a new event when empty or being drained.
  assign load_w = found_w && ((state_q == ST_EMPTY) || ev_ready_i);

  always_comb begin
    dec_w = '0;
    if (load_w) dec_w[grant_w] = 1'b1;
  end

  // Pending counters: simultaneous inc and dec cancel, so a saturated
  // channel being served never overflows.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      pend_d[i]    = pend_q[i];
      ovf_set_w[i] = 1'b0;
      if (edge_w[i] && !dec_w[i]) begin
        if (pend_q[i] == C_CNT_MAX) ovf_set_w[i] = 1'b1;
        else                        pend_d[i] = pend_q[i] + CNT_W'(1);
      end else if (!edge_w[i] && dec_w[i]) begin
        pend_d[i] = pend_q[i] - CNT_W'(1);
      end
    end
    // Set dominates a simultaneous clear.
    ovf_d = (ovf_q & ~ovf_clr_i) | ovf_set_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) pend_q[i] <= '0;
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) pend_q[i] <= pend_d[i];
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      ev_valid_q <= 1'b0;
      ev_ch_q    <= '0;
      ptr_q      <= C_PTR_RST;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (load_w) begin
            ev_ch_q    <= grant_w;
            ptr_q      <= grant_w;
            ev_valid_q <= 1'b1;
            state_q    <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (ev_ready_i) begin
            if (load_w) begin
              ev_ch_q <= grant_w;
              ptr_q   <= grant_w;
            end else begin
              ev_valid_q <= 1'b0;
              state_q    <= ST_EMPTY;
            end
          end
        end
        default: begin
          state_q    <= ST_EMPTY;
          ev_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ev_valid_o = ev_valid_q;
  assign ev_ch_o    = ev_ch_q;
  assign ovf_o      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_edge_event_arbiter
//  Description : Self-checking bench for edge_event_arbiter. Expected event
//                channels are queued when stimulus is driven and compared as
//                transfers appear on the event port. A second instance with
//                both-edge detection covers the EDGE_SEL=2 case.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_edge_event_arbiter;

`ifdef EDGE_ARB_SYNC_EN
  localparam int C_LAT = 4;
`else
  localparam int C_LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_v = '0;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [1:0] ev_ch;
  logic [3:0] ovf;
  logic [3:0] ovf_clr = '0;

  logic [3:0] in2_v = '0;
  logic       ev_ready2 = 1'b0;
  logic       ev_valid2;
  logic [1:0] ev_ch2;
  logic [3:0] ovf2;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int exp2_q[$];

  always #5 clk = ~clk;

  edge_event_arbiter #(.N_CH(4), .CNT_W(3), .EDGE_SEL(0)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_i       (in_v),
    .ev_valid_o (ev_valid),
    .ev_ready_i (ev_ready),
    .ev_ch_o    (ev_ch),
    .ovf_o      (ovf),
    .ovf_clr_i  (ovf_clr)
  );

  edge_event_arbiter #(.N_CH(4), .CNT_W(3), .EDGE_SEL(2)) u_dut_both (
    .clk        (clk),
    .rst        (rst),
    .in_i       (in2_v),
    .ev_valid_o (ev_valid2),
    .ev_ready_i (ev_ready2),
    .ev_ch_o    (ev_ch2),
    .ovf_o      (ovf2),
    .ovf_clr_i  (4'b0000)
  );

  // Scoreboard: every transfer pops one expected channel.
  always @(negedge clk) begin
    int e;
    if (ev_valid && ev_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ev_unexpected: got ch=%0d required no event", ev_ch);
      end else begin
        e = exp_q.pop_front();
        if (int'(ev_ch) !== e) begin
          errors++;
          $display("FAIL ev_ch: got %0d required %0d", ev_ch, e);
        end
      end
    end
    if (ev_valid2 && ev_ready2) begin
      checks++;
      if (exp2_q.size() == 0) begin
        errors++;
        $display("FAIL ev2_unexpected: got ch=%0d required no event", ev_ch2);
      end else begin
        e = exp2_q.pop_front();
        if (int'(ev_ch2) !== e) begin
          errors++;
          $display("FAIL ev2_ch: got %0d required %0d", ev_ch2, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_v = '0; in2_v = '0; ovf_clr = '0;
    ev_ready = 1'b0; ev_ready2 = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", ev_valid); end
    checks++; if (ev_ch !== 2'd0) begin errors++; $display("FAIL rst_ch: got %0d required 0", ev_ch); end
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL rst_ovf: got %b required 0000", ovf); end
    checks++; if (ev_valid2 !== 1'b0) begin errors++; $display("FAIL rst_valid2: got %b required 0", ev_valid2); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int n;
    do_reset();
    ev_ready = 1'b1;
    exp_q.push_back(2);
    in_v[2] = 1'b1;
    tick();
    in_v[2] = 1'b0;
    n = 1;
    while (ev_valid !== 1'b1 && n < 12) begin tick(); n++; end
    checks++; if (n !== C_LAT) begin errors++; $display("FAIL single_latency: got %0d clocks required %0d", n, C_LAT); end
    tick();
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL single_width: got valid=%b required 0", ev_valid); end
    repeat (4) tick();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL single_drain: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    in_v = 4'b1011;
    tick();
    in_v = '0;
    repeat (C_LAT + 1) tick();
    checks++; if (ev_valid !== 1'b1 || ev_ch !== 2'd0) begin
      errors++; $display("FAIL simul_first: got valid=%b ch=%0d required valid=1 ch=0", ev_valid, ev_ch);
    end
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
    ev_ready = 1'b1;
    repeat (3) tick();
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL simul_end: got valid=%b required 0", ev_valid); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL simul_drain: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int p = 0; p < 8; p++) begin
      in_v[1] = 1'b1; tick(); in_v[1] = 1'b0; tick();
    end
    repeat (3) tick();
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL sat_no_ovf_at_8: got %b required 0000", ovf); end
    in_v[1] = 1'b1; tick(); in_v[1] = 1'b0;
    repeat (4) tick();
    checks++; if (ovf !== 4'b0010) begin errors++; $display("FAIL sat_ovf_set: got %b required 0010", ovf); end
    for (int k = 0; k < 8; k++) exp_q.push_back(1);
    ev_ready = 1'b1;
    repeat (12) tick();
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL sat_end: got valid=%b required 0", ev_valid); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL sat_count: got %0d missing required 0", exp_q.size()); end
    checks++; if (ovf !== 4'b0010) begin errors++; $display("FAIL sat_sticky: got %b required 0010", ovf); end
    ovf_clr[1] = 1'b1; tick(); ovf_clr[1] = 1'b0; tick();
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL sat_clear: got %b required 0000", ovf); end
  endtask

  task automatic test_fairness();
    do_reset();
    ev_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin exp_q.push_back(0); exp_q.push_back(2); end
    for (int t = 0; t < 16; t++) begin
      in_v[0] = (t % 2 == 0);
      in_v[2] = (t % 2 == 0);
      tick();
    end
    in_v = '0;
    repeat (20) tick();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL fair_drain: got %0d left required 0", exp_q.size()); end
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL fair_end: got valid=%b required 0", ev_valid); end
  endtask

  task automatic test_reset_mid();
    int seen;
    // Level held high through reset must not produce an event.
    in_v = 4'b1000; rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0; ev_ready = 1'b1;
    seen = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (ev_valid === 1'b1) seen++;
    end
    in_v = '0;
    checks++; if (seen !== 0) begin errors++; $display("FAIL hold_through_rst: got %0d valid cycles required 0", seen); end
    // Reset while FULL with pending work and an overflow.
    do_reset();
    for (int p = 0; p < 9; p++) begin
      in_v[2] = 1'b1; in_v[1] = (p < 4);
      tick();
      in_v = '0;
      tick();
    end
    repeat (4) tick();
    checks++; if (ev_valid !== 1'b1 || ev_ch !== 2'd1) begin
      errors++; $display("FAIL mid_full: got valid=%b ch=%0d required valid=1 ch=1", ev_valid, ev_ch);
    end
    checks++; if (ovf !== 4'b0100) begin errors++; $display("FAIL mid_ovf: got %b required 0100", ovf); end
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0; ev_ready = 1'b1;
    repeat (6) tick();
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL mid_after_valid: got %b required 0", ev_valid); end
    checks++; if (ovf !== 4'b0000) begin errors++; $display("FAIL mid_after_ovf: got %b required 0000", ovf); end
  endtask

  task automatic test_both_edges();
    int first;
    do_reset();
    ev_ready2 = 1'b1;
    exp2_q.push_back(0); exp2_q.push_back(0);
    first = -1;
    in2_v[0] = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (t == 5) in2_v[0] = 1'b0;
      if (first < 0 && ev_valid2 === 1'b1) first = t;
    end
    checks++; if (first !== C_LAT) begin errors++; $display("FAIL both_latency: got %0d clocks required %0d", first, C_LAT); end
    checks++; if (exp2_q.size() !== 0) begin errors++; $display("FAIL both_count: got %0d missing required 0", exp2_q.size()); end
    checks++; if (ev_valid2 !== 1'b0) begin errors++; $display("FAIL both_end: got valid=%b required 0", ev_valid2); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_saturate();
    test_fairness();
    test_reset_mid();
    test_both_edges();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
